// File: rtl/einsum_mult_arbiter.sv
// Purpose: round-robin sharing of one einsum_mult between NUM_REQ requesters, results tagged by requester ID.
// Latency: a request granted in cycle t shows rsp_valid at t+2 at the earliest (1 mux cycle, 1 multiplier stage, FIFO write).
// Backpressure: issue is allowed only while FIFO entries plus the in-flight op are below FIFO_DEPTH; rsp_ready=0 stalls after FIFO_DEPTH ops.

// Small synchronous FIFO with registered occupancy count; output reads as zero when empty.
module einsum_rsp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {AW'(0), push} - {AW'(0), pop};
    end
  end

  // Storage array; contents are meaningless until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Head entry presented combinationally, forced to zero while empty.
  always_comb begin
    empty = (count == '0);
    rdata = empty ? '0 : mem[rd_ptr];
  end

endmodule

// Top level: arbitration, multiplier drive, in-flight tracking and response buffering.
module einsum_mult_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]          req_mode,
  input  logic [NUM_REQ-1:0]            req_bypass,
  output logic                          mult_enable,
  output logic                          mult_bypass,
  output logic [WORD_WIDTH-1:0]         mult_operand_a,
  output logic [WORD_WIDTH-1:0]         mult_operand_b,
  output logic [1:0]                    mult_pe_mode,
  input  logic [WORD_WIDTH-1:0]         mult_product,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WORD_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ID_WIDTH + WORD_WIDTH;

  logic [ID_WIDTH-1:0] rr_ptr;
  logic                inflight;
  logic [ID_WIDTH-1:0] inflight_id;

  logic [AW:0]         fifo_count;
  logic                fifo_empty;
  logic [PW-1:0]       fifo_rdata;
  logic                fifo_pop;

  logic [AW+1:0]       occupancy;
  logic                credit_ok;
  logic                found;
  logic [ID_WIDTH-1:0] win_idx;
  int                  pos;
  logic                grant;

  // Credit: a slot must be reserved for the op already in the multiplier; a same-cycle pop does not count.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight};
    credit_ok = (occupancy < (AW+2)'(FIFO_DEPTH));
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req_valid[pos]) begin
        found   = 1'b1;
        win_idx = ID_WIDTH'(pos);
      end
    end
  end

  assign grant = found & credit_ok & ~rst;

  // Drive the winner's payload onto the multiplier; everything reads zero when nothing issues.
  always_comb begin
    req_ready      = '0;
    mult_enable    = 1'b0;
    mult_bypass    = 1'b0;
    mult_operand_a = '0;
    mult_operand_b = '0;
    mult_pe_mode   = '0;
    if (grant) begin
      req_ready      = NUM_REQ'(1) << win_idx;
      mult_enable    = 1'b1;
      mult_bypass    = req_bypass[win_idx];
      mult_operand_a = req_a[int'(win_idx)*WORD_WIDTH +: WORD_WIDTH];
      mult_operand_b = req_b[int'(win_idx)*WORD_WIDTH +: WORD_WIDTH];
      mult_pe_mode   = req_mode[int'(win_idx)*2 +: 2];
    end
  end

  // Pointer advance past the winner and one-stage tracking of the multiplier result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight <= grant;
      if (grant) begin
        inflight_id <= win_idx;
        rr_ptr      <= (win_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + ID_WIDTH'(1);
      end
    end
  end

  assign fifo_pop = rsp_valid & rsp_ready;

  einsum_rsp_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (fifo_pop),
    .wdata ({inflight_id, mult_product}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Response side and status, all held low while reset is asserted.
  always_comb begin
    rsp_valid = ~rst & ~fifo_empty;
    busy      = ~rst & (inflight | ~fifo_empty);
    rsp_id    = fifo_rdata[PW-1 -: ID_WIDTH];
    rsp_data  = fifo_rdata[WORD_WIDTH-1:0];
  end

endmodule
